// File: rtl/memory_64x32.sv
// Single-port synchronous word memory with registered read data, write-first
// behaviour, out-of-range detection and a synchronous clear of every word.
module memory_64x32 #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] address,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  data_out,
   output logic              addr_err
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             addr_err_q, addr_err_d;
   logic             in_range;
   logic [IdxW-1:0]  idx;

   // Full-width compare so addresses at or above DEPTH never alias onto low words.
   assign in_range = (32'(address) < DEPTH);
   assign idx      = address[IdxW-1:0];

   // Next-state for the storage array: only an in-range write touches a word.
   always_comb begin
      mem_d = mem_q;
      if (write_enable && in_range) begin
         mem_d[idx] = data_in;
      end
   end

   // Next-state for the read port: write-first data, zero plus error flag when out of range.
   always_comb begin
      data_out_d = '0;
      addr_err_d = 1'b0;
      if (!in_range) begin
         addr_err_d = 1'b1;
      end else if (write_enable) begin
         data_out_d = data_in;
      end else begin
         data_out_d = mem_q[idx];
      end
   end

   // State update; reset clears every word and discards any concurrent write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q      <= '{default: '0};
         data_out_q <= '0;
         addr_err_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         data_out_q <= data_out_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign data_out = data_out_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_memory_64x32.sv
// Directed self-checking bench for memory_64x32.
module tb_memory_64x32;

   logic        clk;
   logic        rst_n;
   logic        write_enable;
   logic [7:0]  address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        addr_err;

   int unsigned n_total;
   int unsigned n_pass;
   logic [31:0] fill [10];

   memory_64x32 #(
      .DEPTH (64),
      .WIDTH (32),
      .ADDR_W(8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .write_enable(write_enable),
      .address     (address),
      .data_in     (data_in),
      .data_out    (data_out),
      .addr_err    (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one access and sample 1 time unit after the rising edge.
   task automatic cycle(input logic we, input logic [7:0] a, input logic [31:0] d);
      write_enable = we;
      address      = a;
      data_in      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      n_total      = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      write_enable = 1'b0;
      address      = '0;
      data_in      = '0;

      // Reset
      cycle(1'b0, 8'd0, 32'd0);
      cycle(1'b0, 8'd0, 32'd0);
      check("reset_data_out", data_out, 32'h0);
      check("reset_addr_err", {31'b0, addr_err}, 32'h0);
      rst_n = 1'b1;
      cycle(1'b0, 8'd7, 32'd0);
      check("post_reset_read7", data_out, 32'h0);

      // Sequential fill and readback; write-first visible on each write edge
      for (int i = 0; i < 10; i++) begin
         fill[i] = $urandom;
         cycle(1'b1, 8'(i), fill[i]);
         check($sformatf("fill_wf_%0d", i), data_out, fill[i]);
      end
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 8'(i), 32'h0);
         check($sformatf("fill_rd_%0d", i), data_out, fill[i]);
      end

      // Boundaries
      cycle(1'b1, 8'd63, 32'hDEADBEEF);
      cycle(1'b1, 8'd0, 32'h12345678);
      cycle(1'b0, 8'd63, 32'h0);
      check("rd63", data_out, 32'hDEADBEEF);
      check("rd63_err", {31'b0, addr_err}, 32'h0);
      cycle(1'b0, 8'd0, 32'h0);
      check("rd0", data_out, 32'h12345678);

      // Out of range
      cycle(1'b1, 8'd64, 32'hFFFFFFFF);
      check("oor64_data", data_out, 32'h0);
      check("oor64_err", {31'b0, addr_err}, 32'h1);
      cycle(1'b1, 8'd225, 32'hFFFFFFFF);
      check("oor225_data", data_out, 32'h0);
      check("oor225_err", {31'b0, addr_err}, 32'h1);
      cycle(1'b0, 8'd0, 32'h0);
      check("rd0_after_oor", data_out, 32'h12345678);
      check("rd0_err_clear", {31'b0, addr_err}, 32'h0);
      cycle(1'b0, 8'd255, 32'h0);
      check("oor255_rd_data", data_out, 32'h0);
      check("oor255_rd_err", {31'b0, addr_err}, 32'h1);

      // Read-during-write
      cycle(1'b1, 8'd5, 32'hA5A5A5A5);
      check("rdw_same_edge", data_out, 32'hA5A5A5A5);
      cycle(1'b0, 8'd5, 32'h0);
      check("rdw_readback", data_out, 32'hA5A5A5A5);

      // Reset mid-operation with a write presented
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 32'h100 + 32'(i));
      cycle(1'b1, 8'd64, 32'h0);
      rst_n = 1'b0;
      cycle(1'b1, 8'd3, 32'h55);
      rst_n = 1'b1;
      check("midrst_data_out", data_out, 32'h0);
      check("midrst_addr_err", {31'b0, addr_err}, 32'h0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 8'(i), 32'h0);
         check($sformatf("midrst_rd_%0d", i), data_out, 32'h0);
      end
      cycle(1'b0, 8'd63, 32'h0);
      check("midrst_rd63", data_out, 32'h0);

      // Overwrite on consecutive cycles
      cycle(1'b1, 8'd22, 32'h1);
      cycle(1'b1, 8'd22, 32'h2);
      cycle(1'b0, 8'd22, 32'h0);
      check("overwrite22", data_out, 32'h2);

      // Reset pulse strictly between edges has no effect
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      check("glitch_hold_out", data_out, 32'h2);
      cycle(1'b0, 8'd22, 32'h0);
      check("glitch_retain22", data_out, 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
